ysyx_23060077_pipe_ctrl: RTL and testbench
==========================================

Name: ysyx_23060077_pipe_ctrl

Overview:
Central hazard/flow controller for the 5-stage IF/ID/EX/MEM/WB core.
- Drives the wen/stall/flush inputs of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC update.
- Tracks occupancy of each register and sequences redirects against an outstanding instruction fetch.
- Consumer-side counterpart of the pipeline-register block: it decides what every register does on every cycle.

Parameters:
NREG, 4, number of controlled pipeline registers; index 0 = IF/ID … 3 = MEM/WB (fixed at 4 in this design).
CNT_W, 32, width of performance counters (optional feature only).

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-low (asserted when 0)
ifu_valid_i  in  1  fetch response arrives this cycle
ifu_busy_i  in  1  fetch request outstanding, response not yet returned
lsu_busy_i  in  1  MEM stage waiting on memory
exu_busy_i  in  1  multi-cycle EX op (mul/div) in progress
load_use_i  in  1  load-use hazard detected for instruction in ID
fence_i_i  in  1  fence.i in ID
branch_taken_i  in  1  EX redirect request; held by EXU until accepted
trap_i  in  1  WB trap/mret redirect request; held until accepted
reg_wen_o  out  NREG  per-register wen
reg_stall_o  out  NREG  per-register stall
reg_flush_o  out  NREG  per-register flush
pc_wen_o  out  1  PC register update this cycle
pc_sel_o  out  2  0 = sequential, 1 = branch target, 2 = trap vector
drop_fetch_o  out  1  next returning fetch response is stale; IFU discards it
reg_vld_o  out  NREG  tracked occupancy of each register
perf_stall_o  out  CNT_W  stall-cycle counter (optional feature)
perf_flush_o  out  CNT_W  redirect counter (optional feature)

Behaviour:
- State: FSM {NORMAL, DROP}; vld[3:0]. Reset (reset=0, async): FSM = NORMAL, vld = 0, counters = 0.
- All control outputs are combinational from state and inputs. With all inputs 0 after reset: flush = 4'b1111, wen = stall = 0, pc_wen = 0, drop_fetch = 0.
- Per register, exactly one of wen/stall/flush is high every cycle (one-hot, checked by assertion).
- Holds:
  - held(WB) = 0
  - held(MEM) = lsu_busy
  - held(EX) = exu_busy | held(MEM)
  - held(ID) = load_use | fence_wait | held(EX), where fence_wait = fence_i & (vld[1] | vld[2] | vld[3])
  - held(IF) = held(ID)
- Source valid:
  - src_vld[0] = ifu_valid & (FSM == NORMAL)
  - src_vld[i] = vld[i-1] for i = 1..3
- Normal rule for register i (source stage S_i, sink stage S_i+1), priority order:
  1. stall if held(sink)
  2. else wen if src_vld[i] & !held(src)
  3. else flush (bubble)
- Sequential PC: pc_wen = 1 and pc_sel = 0 when wen[0] = 1.
- Trap: accepted when trap_i & !lsu_busy.
  - flush = 4'b1111, pc_wen = 1, pc_sel = 2.
  - Overrides the branch and the normal rule.
  - While lsu_busy = 1, trap is not accepted and the normal rule applies.
- Branch: accepted when branch_taken_i & !held(EX) & no trap accepted.
  - Registers 0 and 1 flush; registers 2 and 3 follow the normal rule.
  - pc_wen = 1, pc_sel = 1.
- Redirect vs. outstanding fetch: on any accepted redirect with ifu_busy = 1 & ifu_valid = 0, FSM goes NORMAL -> DROP.
- In DROP:
  - drop_fetch = 1; src_vld[0] forced 0.
  - When ifu_valid = 1, the response is discarded and FSM -> NORMAL.
  - A further redirect in DROP updates the PC and FSM stays in DROP.
  - A redirect with ifu_valid = 1 in the same cycle discards that response; FSM stays NORMAL.
- Occupancy update: vld[i] <= wen[i] ? 1 : flush[i] ? 0 : vld[i].
- Reset asserted mid-operation: immediate return to reset state regardless of pending holds or redirects.

Optional Feature:
Macro: YSYX_23060077_PIPE_PERF_EN.
- Defined:
  - perf_stall_o increments each cycle any reg_stall_o bit is 1.
  - perf_flush_o increments on each accepted redirect.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: no counter flops; both ports tied to 0.

Test Plan:
- Reset release, all inputs 0 -> flush = 4'b1111, vld = 0, pc_wen = 0 for 3 cycles.
- ifu_valid = 1 for 4 cycles -> wen fills 0001, 0011, 0111, 1111; vld = 4'b1111; pc_wen = 1, pc_sel = 0 each cycle.
- Full pipe, load_use = 1 for 1 cycle -> stall[0] = 1, flush[1] = 1, wen[2] = wen[3] = 1; next cycle vld[1] = 0.
- Full pipe, lsu_busy = 1 for 3 cycles with trap_i = 1 -> trap deferred, stall = 4'b0111, flush[3] = 1; on lsu_busy = 0 -> flush = 4'b1111, pc_sel = 2, vld -> 0.
- branch_taken_i = 1 with ifu_busy = 1 -> flush[1:0] = 2'b11, pc_sel = 1, FSM = DROP, drop_fetch = 1; next ifu_valid discarded (wen[0] = 0), FSM back to NORMAL.
- fence_i = 1 with vld = 4'b1110 -> IF/ID stall until vld[3:1] = 0 (3 cycles), then normal advance; with PERF_EN, perf_stall_o = 3.

Source files
------------

// File: rtl/ysyx_23060077_pipe_ctrl.sv
`default_nettype none
// ysyx_23060077_pipe_ctrl -- hazard/flow controller for the IF/ID/EX/MEM/WB pipeline registers and PC.
// Optional perf counters: define YSYX_23060077_PIPE_PERF_EN.  Rev 1.0
module ysyx_23060077_pipe_ctrl #(
  parameter int NREG  = 4,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ifu_valid_i,
  input  logic             ifu_busy_i,
  input  logic             lsu_busy_i,
  input  logic             exu_busy_i,
  input  logic             load_use_i,
  input  logic             fence_i_i,
  input  logic             branch_taken_i,
  input  logic             trap_i,
  output logic [NREG-1:0]  reg_wen_o,
  output logic [NREG-1:0]  reg_stall_o,
  output logic [NREG-1:0]  reg_flush_o,
  output logic             pc_wen_o,
  output logic [1:0]       pc_sel_o,
  output logic             drop_fetch_o,
  output logic [NREG-1:0]  reg_vld_o,
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_flush_o
);

  localparam logic [0:0] S_NORMAL = 1'b0;
  localparam logic [0:0] S_DROP   = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [NREG-1:0] r_vld;
  logic [4:0]      w_held;
  logic [NREG-1:0] w_src_vld;
  logic [NREG-1:0] w_norm_wen, w_norm_stall, w_norm_flush;
  logic [NREG-1:0] w_wen, w_stall, w_flush;
  logic            w_fence_wait, w_trap_acc, w_br_acc, w_redirect;
  logic            w_pc_wen;
  logic [1:0]      w_pc_sel;

  // w_held is indexed by stage: 0 = IF, 1 = ID, 2 = EX, 3 = MEM, 4 = WB
  always_comb begin
    w_fence_wait = fence_i_i & (|r_vld[3:1]);
    w_held[4]    = 1'b0;
    w_held[3]    = lsu_busy_i;
    w_held[2]    = exu_busy_i | w_held[3];
    w_held[1]    = load_use_i | w_fence_wait | w_held[2];
    w_held[0]    = w_held[1];
    w_src_vld    = {r_vld[2:0], ifu_valid_i & (r_state == S_NORMAL)};
  end

  always_comb begin
    w_norm_wen   = '0;
    w_norm_stall = '0;
    w_norm_flush = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_held[i+1])
        w_norm_stall[i] = 1'b1;
      else if (w_src_vld[i] && !w_held[i])
        w_norm_wen[i] = 1'b1;
      else
        w_norm_flush[i] = 1'b1;
    end
  end

  // A trap waits for an in-flight memory access so the faulting state is precise.
  always_comb begin
    w_trap_acc = trap_i & ~lsu_busy_i;
    w_br_acc   = branch_taken_i & ~w_held[2] & ~w_trap_acc;
    w_redirect = w_trap_acc | w_br_acc;
    w_wen      = w_norm_wen;
    w_stall    = w_norm_stall;
    w_flush    = w_norm_flush;
    w_pc_sel   = 2'd0;
    if (w_trap_acc) begin
      w_wen    = '0;
      w_stall  = '0;
      w_flush  = '1;
      w_pc_sel = 2'd2;
    end else if (w_br_acc) begin
      w_wen[1:0]   = 2'b00;
      w_stall[1:0] = 2'b00;
      w_flush[1:0] = 2'b11;
      w_pc_sel     = 2'd1;
    end
    w_pc_wen = w_redirect | w_wen[0];
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_NORMAL) begin
      if (w_redirect && ifu_busy_i && !ifu_valid_i)
        w_state_nxt = S_DROP;
    end else begin
      if (ifu_valid_i)
        w_state_nxt = S_NORMAL;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_NORMAL;
      r_vld   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= w_wen | (r_vld & ~w_flush);
    end
  end

`ifdef YSYX_23060077_PIPE_PERF_EN
  logic [CNT_W-1:0] r_perf_stall, r_perf_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      r_perf_stall <= r_perf_stall + {{(CNT_W-1){1'b0}}, |w_stall};
      r_perf_flush <= r_perf_flush + {{(CNT_W-1){1'b0}}, w_redirect};
    end
  end

  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`else
  assign perf_stall_o = '0;
  assign perf_flush_o = '0;
`endif

  assign reg_wen_o    = w_wen;
  assign reg_stall_o  = w_stall;
  assign reg_flush_o  = w_flush;
  assign pc_wen_o     = w_pc_wen;
  assign pc_sel_o     = w_pc_sel;
  assign drop_fetch_o = (r_state == S_DROP);
  assign reg_vld_o    = r_vld;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_onehot
    a_onehot: assert property (@(posedge clock) disable iff (!reset)
      $onehot({w_wen[gi], w_stall[gi], w_flush[gi]}));
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060077_pipe_ctrl.sv
`default_nettype none
// Scoreboard bench for ysyx_23060077_pipe_ctrl: directed vectors push expectations, a negedge monitor compares.
module tb_ysyx_23060077_pipe_ctrl;

  localparam int CNT_W = 32;
  localparam logic [7:0] V  = 8'h80, IB = 8'h40, LB = 8'h20, EB = 8'h10;
  localparam logic [7:0] LU = 8'h08, FE = 8'h04, BR = 8'h02, TR = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_v = 8'h00;

  logic [3:0]       wen, stall, flush, vld;
  logic             pc_wen, drop;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] pst, pfl;

  typedef struct packed {
    logic [3:0]  wen, stall, flush, vld;
    logic        pcw, drop;
    logic [1:0]  sel;
    logic [31:0] pst, pfl;
    logic [15:0] idx;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;
  int m_stall = 0;
  int m_flush = 0;
  int vec = 0;

  always #5 clk = ~clk;

  ysyx_23060077_pipe_ctrl #(.NREG(4), .CNT_W(CNT_W)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .ifu_valid_i    (in_v[7]),
    .ifu_busy_i     (in_v[6]),
    .lsu_busy_i     (in_v[5]),
    .exu_busy_i     (in_v[4]),
    .load_use_i     (in_v[3]),
    .fence_i_i      (in_v[2]),
    .branch_taken_i (in_v[1]),
    .trap_i         (in_v[0]),
    .reg_wen_o      (wen),
    .reg_stall_o    (stall),
    .reg_flush_o    (flush),
    .pc_wen_o       (pc_wen),
    .pc_sel_o       (pc_sel),
    .drop_fetch_o   (drop),
    .reg_vld_o      (vld),
    .perf_stall_o   (pst),
    .perf_flush_o   (pfl)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec%0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("wen",        e.idx, {28'd0, wen},    {28'd0, e.wen});
      chk("stall",      e.idx, {28'd0, stall},  {28'd0, e.stall});
      chk("flush",      e.idx, {28'd0, flush},  {28'd0, e.flush});
      chk("vld",        e.idx, {28'd0, vld},    {28'd0, e.vld});
      chk("pc_wen",     e.idx, {31'd0, pc_wen}, {31'd0, e.pcw});
      chk("pc_sel",     e.idx, {30'd0, pc_sel}, {30'd0, e.sel});
      chk("drop_fetch", e.idx, {31'd0, drop},   {31'd0, e.drop});
      chk("perf_stall", e.idx, pst, e.pst);
      chk("perf_flush", e.idx, pfl, e.pfl);
    end
  end

  task automatic step(input logic r, input logic [7:0] iv, input logic [3:0] w, input logic [3:0] s,
                      input logic [3:0] f, input logic pcw, input logic [1:0] sel, input logic dr,
                      input logic [3:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    in_v  = iv;
    e.wen = w; e.stall = s; e.flush = f; e.vld = v;
    e.pcw = pcw; e.sel = sel; e.drop = dr;
    e.idx = 16'(vec);
    vec++;
    if (!r) begin
      m_stall = 0;
      m_flush = 0;
    end
`ifdef YSYX_23060077_PIPE_PERF_EN
    e.pst = 32'(m_stall);
    e.pfl = 32'(m_flush);
`else
    e.pst = 32'd0;
    e.pfl = 32'd0;
`endif
    if (r) begin
      if (s != 4'b0000) m_stall++;
      if (sel != 2'd0) m_flush++;
    end
    q.push_back(e);
  endtask

  initial begin
    // reset held, then idle pipe drains to bubbles
    step(0, 8'h00,   4'b0000, 4'b0000, 4'b1111, 0, 2'd0, 0, 4'b0000);
    for (int i = 0; i < 3; i++)
      step(1, 8'h00, 4'b0000, 4'b0000, 4'b1111, 0, 2'd0, 0, 4'b0000);
    // fill
    step(1, V,       4'b0001, 4'b0000, 4'b1110, 1, 2'd0, 0, 4'b0000);
    step(1, V,       4'b0011, 4'b0000, 4'b1100, 1, 2'd0, 0, 4'b0001);
    step(1, V,       4'b0111, 4'b0000, 4'b1000, 1, 2'd0, 0, 4'b0011);
    step(1, V,       4'b1111, 4'b0000, 4'b0000, 1, 2'd0, 0, 4'b0111);
    // load-use bubble
    step(1, LU,      4'b1100, 4'b0001, 4'b0010, 0, 2'd0, 0, 4'b1111);
    step(1, V,       4'b1011, 4'b0000, 4'b0100, 1, 2'd0, 0, 4'b1101);
    step(1, V,       4'b0111, 4'b0000, 4'b1000, 1, 2'd0, 0, 4'b1011);
    step(1, V,       4'b1111, 4'b0000, 4'b0000, 1, 2'd0, 0, 4'b0111);
    // trap deferred by lsu_busy, then taken
    step(1, LB|TR,   4'b0000, 4'b0111, 4'b1000, 0, 2'd0, 0, 4'b1111);
    step(1, LB|TR,   4'b0000, 4'b0111, 4'b1000, 0, 2'd0, 0, 4'b0111);
    step(1, LB|TR,   4'b0000, 4'b0111, 4'b1000, 0, 2'd0, 0, 4'b0111);
    step(1, TR,      4'b0000, 4'b0000, 4'b1111, 1, 2'd2, 0, 4'b0111);
    step(1, 8'h00,   4'b0000, 4'b0000, 4'b1111, 0, 2'd0, 0, 4'b0000);
    // branch against an outstanding fetch, stale response dropped
    step(1, V,       4'b0001, 4'b0000, 4'b1110, 1, 2'd0, 0, 4'b0000);
    step(1, V,       4'b0011, 4'b0000, 4'b1100, 1, 2'd0, 0, 4'b0001);
    step(1, BR|IB,   4'b0100, 4'b0000, 4'b1011, 1, 2'd1, 0, 4'b0011);
    step(1, V,       4'b1000, 4'b0000, 4'b0111, 0, 2'd0, 1, 4'b0100);
    step(1, V,       4'b0001, 4'b0000, 4'b1110, 1, 2'd0, 0, 4'b1000);
    step(1, V,       4'b0011, 4'b0000, 4'b1100, 1, 2'd0, 0, 4'b0001);
    step(1, V,       4'b0111, 4'b0000, 4'b1000, 1, 2'd0, 0, 4'b0011);
    step(1, 8'h00,   4'b1110, 4'b0000, 4'b0001, 0, 2'd0, 0, 4'b0111);
    // fence.i waits for EX/MEM/WB to drain
    step(1, FE,      4'b1100, 4'b0001, 4'b0010, 0, 2'd0, 0, 4'b1110);
    step(1, FE,      4'b1000, 4'b0001, 4'b0110, 0, 2'd0, 0, 4'b1100);
    step(1, FE,      4'b0000, 4'b0001, 4'b1110, 0, 2'd0, 0, 4'b1000);
    step(1, FE|V,    4'b0001, 4'b0000, 4'b1110, 1, 2'd0, 0, 4'b0000);
    // branch held off by a busy EX, then taken
    step(1, V,       4'b0011, 4'b0000, 4'b1100, 1, 2'd0, 0, 4'b0001);
    step(1, V,       4'b0111, 4'b0000, 4'b1000, 1, 2'd0, 0, 4'b0011);
    step(1, EB|BR,   4'b1000, 4'b0011, 4'b0100, 0, 2'd0, 0, 4'b0111);
    step(1, BR|IB,   4'b0100, 4'b0000, 4'b1011, 1, 2'd1, 0, 4'b1011);
    // second redirect while in DROP, then recovery
    step(1, TR|IB,   4'b0000, 4'b0000, 4'b1111, 1, 2'd2, 1, 4'b0100);
    step(1, V,       4'b0000, 4'b0000, 4'b1111, 0, 2'd0, 1, 4'b0000);
    // redirect coinciding with the fetch response stays NORMAL
    step(1, BR|IB|V, 4'b0000, 4'b0000, 4'b1111, 1, 2'd1, 0, 4'b0000);
    step(1, V,       4'b0001, 4'b0000, 4'b1110, 1, 2'd0, 0, 4'b0000);
    step(1, V,       4'b0011, 4'b0000, 4'b1100, 1, 2'd0, 0, 4'b0001);
    // enter DROP, then async reset mid-operation with a hold pending
    step(1, BR|IB,   4'b0100, 4'b0000, 4'b1011, 1, 2'd1, 0, 4'b0011);
    step(0, LB,      4'b0000, 4'b0111, 4'b1000, 0, 2'd0, 0, 4'b0000);
    step(1, 8'h00,   4'b0000, 4'b0000, 4'b1111, 0, 2'd0, 0, 4'b0000);
    step(1, V,       4'b0001, 4'b0000, 4'b1110, 1, 2'd0, 0, 4'b0000);

    @(posedge clk);
    #1;
    in_v = 8'h00;
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 0, 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
